// File: rtl/dsp_macc_pkg.sv
// Shared widths, DSP feedback codes and sequencer state encoding for the
// vector dot-product sequencer.
package dsp_macc_pkg;

  localparam int A_W = 20;
  localparam int B_W = 18;
  localparam int Z_W = 38;

  localparam logic [2:0] FB_ACCUM = 3'd0;
  localparam logic [2:0] FB_LOAD  = 3'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/dsp_macc_vector_seq.sv
// Dot-product sequencer: feeds operand pairs into a registered-input DSP MACC
// slice, waits out the slice pipeline and presents the accumulated result.
module dsp_macc_vector_seq
  import dsp_macc_pkg::*;
#(
  parameter int DSP_LAT = 2,
  parameter int MAX_LEN = 1024,
  parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  // Handshakes: a transfer happens in any cycle where valid & ready are both
  // high at the rising edge; valid never waits on ready, and a held-off
  // producer keeps its payload stable until it is accepted.
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [A_W-1:0]   s_a,
  input  logic [B_W-1:0]   s_b,
  input  logic             s_last,
  output logic [A_W-1:0]   dsp_a,
  output logic [B_W-1:0]   dsp_b,
  output logic             dsp_load_acc,
  output logic [2:0]       dsp_feedback,
  input  logic [Z_W-1:0]   dsp_z,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [Z_W-1:0]   m_data,
  output logic [CNT_W-1:0] m_count,
  output logic             m_trunc,
  output logic [1:0]       o_dbg_state
);

  localparam int FL_W = (DSP_LAT > 1) ? $clog2(DSP_LAT) : 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_elem_cnt;
  logic [CNT_W-1:0] w_elem_cnt_nxt;
  logic [CNT_W-1:0] w_elem_cnt_inc;
  logic             r_trunc;
  logic             w_trunc_nxt;
  logic [FL_W-1:0]  r_flush_cnt;
  logic [FL_W-1:0]  w_flush_cnt_nxt;
  logic             w_capture;
  logic             w_hs;
  logic [Z_W-1:0]   r_m_data;
  logic [CNT_W-1:0] r_m_count;
  logic             r_m_trunc;

  assign s_ready        = (r_state == IDLE) || (r_state == ACCUM);
  assign w_hs           = s_valid & s_ready;
  assign dsp_a          = s_a;
  assign dsp_b          = s_b;
  assign dsp_load_acc   = w_hs;
  // Only a continuing vector accumulates; every fresh vector reloads the slice.
  assign dsp_feedback   = (r_state == ACCUM) ? FB_ACCUM : FB_LOAD;
  assign m_valid        = (r_state == HOLD);
  assign m_data         = r_m_data;
  assign m_count        = r_m_count;
  assign m_trunc        = r_m_trunc;
  assign o_dbg_state    = r_state;
  assign w_elem_cnt_inc = r_elem_cnt + CNT_W'(1);

  always_comb begin
    w_state_nxt     = r_state;
    w_elem_cnt_nxt  = r_elem_cnt;
    w_trunc_nxt     = r_trunc;
    w_flush_cnt_nxt = r_flush_cnt;
    w_capture       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_hs) begin
          w_elem_cnt_nxt = CNT_W'(1);
          if (s_last || (MAX_LEN == 1)) begin
            w_state_nxt     = FLUSH;
            w_trunc_nxt     = !s_last;
            w_flush_cnt_nxt = FL_W'(DSP_LAT - 1);
          end else begin
            w_state_nxt = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (w_hs) begin
          w_elem_cnt_nxt = w_elem_cnt_inc;
          if (s_last) begin
            w_state_nxt     = FLUSH;
            w_trunc_nxt     = 1'b0;
            w_flush_cnt_nxt = FL_W'(DSP_LAT - 1);
          end else if (w_elem_cnt_inc == CNT_W'(MAX_LEN)) begin
            w_state_nxt     = FLUSH;
            w_trunc_nxt     = 1'b1;
            w_flush_cnt_nxt = FL_W'(DSP_LAT - 1);
          end
        end
      end
      FLUSH: begin
        // The slice needs DSP_LAT cycles after the last operand to show it on dsp_z.
        if (r_flush_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = HOLD;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt - FL_W'(1);
        end
      end
      HOLD: begin
        if (m_ready) begin
          w_state_nxt    = IDLE;
          w_elem_cnt_nxt = '0;
          w_trunc_nxt    = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_elem_cnt  <= '0;
      r_trunc     <= 1'b0;
      r_flush_cnt <= '0;
      r_m_data    <= '0;
      r_m_count   <= '0;
      r_m_trunc   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_elem_cnt  <= w_elem_cnt_nxt;
      r_trunc     <= w_trunc_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      if (w_capture) begin
        r_m_data  <= dsp_z;
        r_m_count <= r_elem_cnt;
        r_m_trunc <= r_trunc;
      end
    end
  end

endmodule
